branch_resolve_unit: RTL and testbench

- Registered, handshaked successor of the combinational flag tester.
- Holds the architectural flag register {O,S,C,Z} and evaluates jf/jt/j/jal/jr conditions against it, with optional same-cycle flag bypass.
- Returns one registered branch decision per accepted request: MX_PC select, resolved next PC and a flush pulse.
- Sits between the decode/execute boundary and the PC mux; also keeps saturating taken/not-taken statistics.

---
 rtl/branch_resolve_unit_if.sv | 27 ++
 rtl/branch_resolve_unit.sv | 124 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Request/result handshake bundle between decode/execute and the branch resolve unit.
interface branch_resolve_unit_if #(
  parameter int unsigned PC_W = 16
);
  logic            br_valid;
  logic            br_ready;
  logic [2:0]      op_tf;
  logic [2:0]      cond;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_inc;
  logic            res_valid;
  logic            res_ready;
  logic            res_sel;
  logic [PC_W-1:0] res_pc;
  logic            res_flush;
  logic            res_illegal;

  modport master (
    output br_valid, op_tf, cond, target, pc_inc, res_ready,
    input  br_ready, res_valid, res_sel, res_pc, res_flush, res_illegal
  );

  modport slave (
    input  br_valid, op_tf, cond, target, pc_inc, res_ready,
    output br_ready, res_valid, res_sel, res_pc, res_flush, res_illegal
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Registered branch resolver: holds {O,S,C,Z}, evaluates jf/jt/j/jal/jr and
// returns one decision per accepted request, plus saturating taken/not-taken counters.
module branch_resolve_unit #(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned CNT_W  = 16,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_unit_if.slave link,
  input  logic                 flags_we,
  input  logic [3:0]           flags_in,
  output logic [3:0]           flags_q,
  input  logic                 stat_clr,
  output logic [CNT_W-1:0]     taken_cnt,
  output logic [CNT_W-1:0]     ntaken_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t          state;
  logic [3:0]      eff;
  logic            ct, cond_bad, take, illegal, is_cond, counted, accept;
  logic            sel_q, flush_q, illegal_q;
  logic [PC_W-1:0] pc_q;

  assign eff = (BYPASS && flags_we) ? flags_in : flags_q;

  // eff bit order: [3]=O [2]=S [1]=C [0]=Z
  always_comb begin
    ct       = 1'b0;
    cond_bad = 1'b0;
    case (link.cond)
      3'b000:  ct = 1'b1;
      3'b001:  ct = eff[2];
      3'b010:  ct = eff[0];
      3'b100:  ct = eff[1];
      3'b101:  ct = eff[2] & eff[0];
      3'b111:  ct = eff[3];
      default: cond_bad = 1'b1;
    endcase
  end

  always_comb begin
    take    = 1'b0;
    illegal = 1'b0;
    is_cond = 1'b0;
    case (link.op_tf)
      3'b000: begin
        is_cond = 1'b1;
        illegal = cond_bad;
        take    = !cond_bad && (link.cond != 3'b000) && !ct;
      end
      3'b001: begin
        is_cond = 1'b1;
        illegal = cond_bad;
        take    = !cond_bad && ct;
      end
      3'b010, 3'b011, 3'b100: take = 1'b1;
      3'b111:                 take = 1'b0;
      default:                illegal = 1'b1;
    endcase
  end

  assign link.br_ready   = (state == EMPTY) || link.res_ready;
  assign link.res_valid  = (state == FULL);
  assign link.res_sel    = sel_q;
  assign link.res_pc     = pc_q;
  assign link.res_flush  = flush_q;
  assign link.res_illegal = illegal_q;

  assign accept  = link.br_valid && link.br_ready;
  assign counted = accept && !illegal && (link.op_tf != 3'b111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (flags_we) begin
      flags_q <= flags_in;
    end
  end

  // flush is cleared when draining so it stays qualified by res_valid while still flopped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      sel_q     <= 1'b1;
      pc_q      <= '0;
      flush_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        state     <= FULL;
        sel_q     <= !take;
        pc_q      <= take ? link.target : link.pc_inc;
        flush_q   <= take;
        illegal_q <= illegal;
      end else if (state == FULL && link.res_ready) begin
        state   <= EMPTY;
        flush_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt  <= '0;
      ntaken_cnt <= '0;
    end else if (stat_clr) begin
      taken_cnt  <= '0;
      ntaken_cnt <= '0;
    end else if (counted) begin
      if (take && taken_cnt != CNT_MAX) begin
        taken_cnt <= taken_cnt + 1'b1;
      end
      if (!take && is_cond && ntaken_cnt != CNT_MAX) begin
        ntaken_cnt <= ntaken_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; a BYPASS=0 twin shares the stimulus.
module tb_branch_resolve_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flags_we;
  logic [3:0] flags_in;
  logic       stat_clr;
  logic [3:0] flags_q, flags_q0;
  logic [3:0] taken_cnt, ntaken_cnt;
  logic [3:0] taken_cnt0, ntaken_cnt0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.PC_W(16)) bi ();
  branch_resolve_unit_if #(.PC_W(16)) b0 ();

  assign b0.br_valid  = bi.br_valid;
  assign b0.op_tf     = bi.op_tf;
  assign b0.cond      = bi.cond;
  assign b0.target    = bi.target;
  assign b0.pc_inc    = bi.pc_inc;
  assign b0.res_ready = bi.res_ready;

  branch_resolve_unit #(.PC_W(16), .CNT_W(4), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .link(bi.slave),
    .flags_we(flags_we), .flags_in(flags_in), .flags_q(flags_q),
    .stat_clr(stat_clr), .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
  );

  branch_resolve_unit #(.PC_W(16), .CNT_W(4), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .link(b0.slave),
    .flags_we(flags_we), .flags_in(flags_in), .flags_q(flags_q0),
    .stat_clr(stat_clr), .taken_cnt(taken_cnt0), .ntaken_cnt(ntaken_cnt0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] cd;
    logic       sel;
  } vec_t;

  // flags held at {O,S,C,Z}=0101 while these run
  vec_t vecs [12] = '{
    '{3'b001, 3'b000, 1'b0},  // jt.true
    '{3'b001, 3'b010, 1'b0},  // jt.zero
    '{3'b001, 3'b100, 1'b1},  // jt.carry
    '{3'b001, 3'b101, 1'b0},  // jt.negzero
    '{3'b001, 3'b111, 1'b1},  // jt.ovf
    '{3'b000, 3'b000, 1'b1},  // jf.true
    '{3'b000, 3'b100, 1'b0},  // jf.carry
    '{3'b000, 3'b111, 1'b0},  // jf.ovf
    '{3'b000, 3'b010, 1'b1},  // jf.zero
    '{3'b011, 3'b000, 1'b0},  // jal
    '{3'b100, 3'b000, 1'b0},  // jr
    '{3'b111, 3'b000, 1'b1}   // non-branch
  };

  initial begin
    rst_n        = 1'b0;
    flags_we     = 1'b0;
    flags_in     = 4'h0;
    stat_clr     = 1'b0;
    bi.br_valid  = 1'b0;
    bi.op_tf     = 3'b111;
    bi.cond      = 3'b000;
    bi.target    = 16'h0040;
    bi.pc_inc    = 16'h0011;
    bi.res_ready = 1'b1;
    repeat (2) step();
    check("rst_valid", bi.res_valid, 0);
    check("rst_sel", bi.res_sel, 1);
    check("rst_pc", bi.res_pc, 0);
    check("rst_flags", flags_q, 0);
    check("rst_taken", taken_cnt, 0);
    rst_n = 1'b1;
    step();

    flags_we = 1'b1; flags_in = 4'b0101;
    step();
    flags_we = 1'b0;
    check("flags_load", flags_q, 4'b0101);

    bi.br_valid = 1'b1; bi.op_tf = 3'b001; bi.cond = 3'b001;
    step();
    check("jtneg_valid", bi.res_valid, 1);
    check("jtneg_sel", bi.res_sel, 0);
    check("jtneg_pc", bi.res_pc, 16'h0040);
    check("jtneg_flush", bi.res_flush, 1);
    bi.op_tf = 3'b000;
    step();
    check("jfneg_sel", bi.res_sel, 1);
    check("jfneg_pc", bi.res_pc, 16'h0011);
    check("jfneg_flush", bi.res_flush, 0);

    for (int unsigned i = 0; i < 12; i++) begin
      bi.op_tf = vecs[i].op;
      bi.cond  = vecs[i].cd;
      step();
      check($sformatf("vec%0d_sel", i), bi.res_sel, vecs[i].sel);
      check($sformatf("vec%0d_pc", i), bi.res_pc, vecs[i].sel ? 16'h0011 : 16'h0040);
      check($sformatf("vec%0d_flush", i), bi.res_flush, !vecs[i].sel);
      check($sformatf("vec%0d_ill", i), bi.res_illegal, 0);
    end
    bi.br_valid = 1'b0;
    step();
    check("drain_valid", bi.res_valid, 0);
    check("drain_flush", bi.res_flush, 0);
    check("sweep_taken", taken_cnt, 8);
    check("sweep_ntaken", ntaken_cnt, 5);

    flags_we = 1'b1; flags_in = 4'b0000;
    step();
    flags_in = 4'b0001; bi.br_valid = 1'b1; bi.op_tf = 3'b001; bi.cond = 3'b010;
    step();
    flags_we = 1'b0; bi.br_valid = 1'b0;
    check("bypass1_sel", bi.res_sel, 0);
    check("bypass0_sel", b0.res_sel, 1);
    check("bypass1_flags", flags_q, 4'b0001);
    check("bypass0_flags", flags_q0, 4'b0001);
    step();

    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("clr_taken", taken_cnt, 0);
    check("clr_ntaken", ntaken_cnt, 0);

    bi.res_ready = 1'b0; bi.br_valid = 1'b1; bi.op_tf = 3'b010;
    bi.target = 16'h0100; bi.pc_inc = 16'h0002;
    step();
    check("bp_first_pc", bi.res_pc, 16'h0100);
    bi.target = 16'h0200;
    stat_clr = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      check($sformatf("bp_ready%0d", i), bi.br_ready, 0);
      step();
      stat_clr = 1'b0;
      check($sformatf("bp_valid%0d", i), bi.res_valid, 1);
      check($sformatf("bp_pc%0d", i), bi.res_pc, 16'h0100);
    end
    bi.res_ready = 1'b1; bi.target = 16'h0201;
    for (int unsigned i = 1; i <= 4; i++) begin
      step();
      check($sformatf("b2b_valid%0d", i), bi.res_valid, 1);
      check($sformatf("b2b_pc%0d", i), bi.res_pc, 16'h0200 + i);
      bi.target = 16'(16'h0201 + i);
    end
    bi.br_valid = 1'b0;
    step();
    check("b2b_drain", bi.res_valid, 0);
    check("b2b_taken", taken_cnt, 4);

    bi.br_valid = 1'b1; bi.op_tf = 3'b110; bi.cond = 3'b000;
    step();
    check("ill_op", bi.res_illegal, 1);
    check("ill_op_sel", bi.res_sel, 1);
    check("ill_op_flush", bi.res_flush, 0);
    bi.op_tf = 3'b001; bi.cond = 3'b011;
    step();
    check("ill_cond", bi.res_illegal, 1);
    check("ill_cond_sel", bi.res_sel, 1);
    bi.br_valid = 1'b0;
    step();
    check("ill_taken", taken_cnt, 4);
    check("ill_ntaken", ntaken_cnt, 0);

    bi.br_valid = 1'b1; bi.op_tf = 3'b010;
    repeat (17) step();
    check("sat_taken", taken_cnt, 15);
    check("sat_legal", bi.res_illegal, 0);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check("clr_wins", taken_cnt, 0);
    step();
    check("mid_valid", bi.res_valid, 1);
    check("mid_taken", taken_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", bi.res_valid, 0);
    check("async_flags", flags_q, 0);
    check("async_taken", taken_cnt, 0);
    check("async_sel", bi.res_sel, 1);
    bi.br_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
